// File: rtl/pe_stream_pkg.sv
// Shared types and sizing helpers for the padded column streamer.
package pe_stream_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PADC = 3'd1,
    FILL = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int DEF_DW    = 8;
  localparam int DEF_IMG_W = 32;
  localparam int DEF_IMG_H = 24;
  localparam int DEF_PAD   = 1;

  localparam int COLS_OUT = DEF_IMG_W + 2 * DEF_PAD;
  localparam int ROWS_OUT = DEF_IMG_H + 2 * DEF_PAD;

  // Index width for n distinct values, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cols_out(input int img_w, input int pad);
    return img_w + 2 * pad;
  endfunction

  function automatic int rows_out(input int img_h, input int pad);
    return img_h + 2 * pad;
  endfunction

endpackage

// File: rtl/pe_col_shiftreg.sv
// Column assembly register: ROWS slots of DW bits, slot 0 packed at the MSBs.
// fill_en loads every slot with fill_data; otherwise wr_en loads wr_data into
// every slot in the inclusive range wr_lo..wr_hi.
module pe_col_shiftreg
  import pe_stream_pkg::*;
#(
  parameter int DW   = 8,
  parameter int ROWS = 26,
  parameter int SW   = addr_w(ROWS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fill_en,
  input  logic [DW-1:0]      fill_data,
  input  logic               wr_en,
  input  logic [SW-1:0]      wr_lo,
  input  logic [SW-1:0]      wr_hi,
  input  logic [DW-1:0]      wr_data,
  output logic [ROWS*DW-1:0] col_data
);

  logic [DW-1:0] slot [ROWS];

  // Slot storage: whole-column pad fill has priority over the ranged write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ROWS; k++) slot[k] <= '0;
    end else begin
      for (int k = 0; k < ROWS; k++) begin
        if (fill_en) begin
          slot[k] <= fill_data;
        end else if (wr_en && (SW'(k) >= wr_lo) && (SW'(k) <= wr_hi)) begin
          slot[k] <= wr_data;
        end
      end
    end
  end

  for (genvar k = 0; k < ROWS; k++) begin : g_pack
    assign col_data[(ROWS-1-k)*DW +: DW] = slot[k];
  end

endmodule

// File: rtl/pe_col_streamer.sv
// Streams one stored frame from the ping-pong buffer to the PE array as
// padded parallel columns under a valid/ready handshake.
// Build macro PE_PAD_REPLICATE_EN: pad slots and pad columns replicate the
// nearest edge pixel instead of using pad_value.
module pe_col_streamer
  import pe_stream_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IMG_W = 32,
  parameter int IMG_H = 24,
  parameter int PAD   = 1,
  parameter int AW    = addr_w(IMG_W * IMG_H)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DW-1:0]                    pad_value,
  input  logic                             frame_ready,
  output logic [AW-1:0]                    rd_addr,
  output logic                             rd_en,
  input  logic [DW-1:0]                    rd_data,
  output logic                             frame_release,
  output logic [(IMG_H+2*PAD)*DW-1:0]      col_data,
  output logic                             col_vld,
  input  logic                             col_rdy,
  output logic [$clog2(IMG_W+2*PAD+1)-1:0] col_idx,
  output logic                             col_last,
  output logic                             busy
);

`ifdef PE_PAD_REPLICATE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  localparam int ROWS_N = rows_out(IMG_H, PAD);
  localparam int COLS_N = cols_out(IMG_W, PAD);
  localparam int CIW    = $clog2(COLS_N + 1);
  localparam int SW     = addr_w(ROWS_N);
  localparam int FW     = addr_w(IMG_H + 1);

  localparam logic [CIW-1:0] LAST_IDX  = CIW'(COLS_N - 1);
  localparam logic [FW-1:0]  FCNT_END  = FW'(IMG_H);
  localparam logic [FW-1:0]  FCNT_LRD  = FW'(IMG_H - 1);
  // With replication, the left pad columns reuse the fill of image column 0.
  localparam int             LEFT_END  = REPL ? PAD + 1 : PAD;
  localparam state_t         START_ST  = (PAD > 0 && !REPL) ? PADC : FILL;

  state_t         state, state_nx;
  logic [FW-1:0]  fcnt;
  logic [AW-1:0]  row_addr;
  logic [DW-1:0]  pad_q;
  logic [CIW-1:0] nxt_idx;
  logic           nxt_is_pad;
  int             up_idx;
  logic [AW-1:0]  first_addr;
  logic           fill_en, wr_en;
  logic [SW-1:0]  wr_lo, wr_hi, cap_slot;

  assign nxt_idx  = col_idx + 1'b1;
  assign cap_slot = SW'(PAD + int'(fcnt) - 1);
  assign rd_addr  = row_addr;
  assign busy     = (state != IDLE);

  // Column classification and first-row address of the column about to be filled.
  always_comb begin
    nxt_is_pad = (int'(nxt_idx) < LEFT_END) || (int'(nxt_idx) >= PAD + IMG_W);
    up_idx     = (state == IDLE) ? 0 : int'(nxt_idx);
    first_addr = (up_idx < PAD) ? '0 : AW'(up_idx - PAD);
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_nx      = state;
    fill_en       = 1'b0;
    wr_en         = 1'b0;
    wr_lo         = cap_slot;
    wr_hi         = cap_slot;
    rd_en         = 1'b0;
    col_vld       = 1'b0;
    col_last      = 1'b0;
    frame_release = 1'b0;
    case (state)
      IDLE: if (frame_ready) state_nx = START_ST;
      PADC: begin
        fill_en  = !REPL;
        state_nx = EMIT;
      end
      FILL: begin
        rd_en   = (fcnt != FCNT_END);
        fill_en = !REPL && (fcnt == '0);
        wr_en   = (fcnt != '0);
        if (REPL && fcnt == FW'(1)) wr_lo = '0;
        if (REPL && fcnt == FCNT_END) wr_hi = SW'(ROWS_N - 1);
        if (fcnt == FCNT_END) state_nx = EMIT;
      end
      EMIT: begin
        col_vld  = 1'b1;
        col_last = (col_idx == LAST_IDX);
        if (col_rdy) begin
          if (col_idx == LAST_IDX) state_nx = DONE;
          else state_nx = nxt_is_pad ? PADC : FILL;
        end
      end
      DONE: begin
        frame_release = 1'b1;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, column index, fill counter, read address and latched pad value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      col_idx  <= '0;
      fcnt     <= '0;
      row_addr <= '0;
      pad_q    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && frame_ready) begin
        pad_q   <= pad_value;
        col_idx <= '0;
      end
      if (state == EMIT && col_rdy && col_idx != LAST_IDX) col_idx <= nxt_idx;
      if (state == DONE) col_idx <= '0;
      if (state_nx == FILL && state != FILL) begin
        fcnt     <= '0;
        row_addr <= first_addr;
      end else if (state == FILL) begin
        if (fcnt != FCNT_END) fcnt <= fcnt + 1'b1;
        if (rd_en && fcnt != FCNT_LRD) row_addr <= row_addr + AW'(IMG_W);
      end
    end
  end

  pe_col_shiftreg #(
    .DW   (DW),
    .ROWS (ROWS_N),
    .SW   (SW)
  ) u_col (
    .clk       (clk),
    .rst_n     (rst_n),
    .fill_en   (fill_en),
    .fill_data (pad_q),
    .wr_en     (wr_en),
    .wr_lo     (wr_lo),
    .wr_hi     (wr_hi),
    .wr_data   (rd_data),
    .col_data  (col_data)
  );

endmodule
